// File: rtl/spi_slave_sync.sv
// -----------------------------------------------------------------------------
// spi_slave_sync
//
// SPI slave that runs entirely on sysclk. SCLK, MOSI and CS are oversampled
// through synchroniser chains and are never used as clocks. Supports any word
// width >= 2, all four CPOL/CPHA modes, a one-deep TX holding register with a
// valid/ready handshake, and underrun / frame-error reporting.
//
// Parameters
//   WIDTH        bits per SPI word (>= 2), MSB first on MOSI and MISO
//   CPOL         SCLK idle level
//   CPHA         0: sample on first edge, shift on second
//                1: shift on first edge, sample on second
//   SYNC_STAGES  synchroniser depth on SCLK/MOSI/CS (>= 2)
//   TX_FILL      word sent when the holding register is empty at a word load
//
// Ports
//   sysclk       fabric clock, all state on its rising edge
//   nReset       asynchronous active-low reset
//   oRx          last complete received word, held until the next completes
//   oRxReady     one-cycle pulse when oRx is updated
//   iTx          word to transmit
//   iTxValid     iTx valid; accepted when iTxValid & oTxReady
//   oTxReady     TX holding register empty
//   oTxUnderrun  one-cycle pulse: a word load found the holding register empty
//   oFrameErr    one-cycle pulse: CS released with a partial word received
//   iSPIClk      SCLK pin (asynchronous)
//   iSPIMOSI     MOSI pin (asynchronous)
//   iSPICS       chip select pin, active low (asynchronous)
//   oSPIMISO     MISO data, 0 while not selected
//   oSPIMisoOe   MISO output enable (frame active)
//
// Optional build macro
//   SPI_SLAVE_PROBE_EN  adds output probe[15:0] =
//       {frame_active, holding_full, underrun_sticky, frame_err_sticky,
//        4'b0, bit_count[7:0]}
//   The sticky bits are cleared only by nReset. Without the macro the port and
//   the sticky flops do not exist and behaviour is otherwise identical.
// -----------------------------------------------------------------------------
module spi_slave_sync #(
    parameter int               WIDTH       = 8,
    parameter int               CPOL        = 0,
    parameter int               CPHA        = 0,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] TX_FILL     = '0
) (
    input  logic             sysclk,
    input  logic             nReset,
    output logic [WIDTH-1:0] oRx,
    output logic             oRxReady,
    input  logic [WIDTH-1:0] iTx,
    input  logic             iTxValid,
    output logic             oTxReady,
    output logic             oTxUnderrun,
    output logic             oFrameErr,
    input  logic             iSPIClk,
    input  logic             iSPIMOSI,
    input  logic             iSPICS,
    output logic             oSPIMISO,
    output logic             oSPIMisoOe
`ifdef SPI_SLAVE_PROBE_EN
    ,
    output logic [15:0]      probe
`endif
);

    localparam int         CNT_W          = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic       IDLE_CLK       = (CPOL != 0);
    // Data is sampled on the rising SCLK edge when CPOL and CPHA agree.
    localparam logic       SAMPLE_ON_RISE = (CPOL == CPHA);
    localparam logic       SHIFT_FIRST    = (CPHA != 0);

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } state_t;

    // ------------------------------------------------------------------
    // Pin synchronisers plus one history flop for edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sclk_sync_reg;
    logic [SYNC_STAGES-1:0] mosi_sync_reg;
    logic [SYNC_STAGES-1:0] cs_sync_reg;
    logic                   sclk_hist_reg;
    logic                   cs_hist_reg;

    // The CS chain resets to "selected" (0). A CS pin that is already low
    // when reset is released therefore produces no falling edge; the slave
    // waits for CS to go high and then low again before starting a frame.
    always_ff @(posedge sysclk or negedge nReset) begin
        if (!nReset) begin
            sclk_sync_reg <= {SYNC_STAGES{IDLE_CLK}};
            mosi_sync_reg <= '0;
            cs_sync_reg   <= '0;
            sclk_hist_reg <= IDLE_CLK;
            cs_hist_reg   <= 1'b0;
        end else begin
            sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], iSPIClk};
            mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], iSPIMOSI};
            cs_sync_reg   <= {cs_sync_reg[SYNC_STAGES-2:0], iSPICS};
            sclk_hist_reg <= sclk_sync_reg[SYNC_STAGES-1];
            cs_hist_reg   <= cs_sync_reg[SYNC_STAGES-1];
        end
    end

    logic sclk_s;
    logic mosi_s;
    logic cs_s;
    logic sclk_rise;
    logic sclk_fall;
    logic cs_rise;
    logic cs_fall;

    assign sclk_s    = sclk_sync_reg[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_reg[SYNC_STAGES-1];
    assign cs_s      = cs_sync_reg[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_hist_reg;
    assign sclk_fall = ~sclk_s & sclk_hist_reg;
    assign cs_rise   = cs_s & ~cs_hist_reg;
    assign cs_fall   = ~cs_s & cs_hist_reg;

    // ------------------------------------------------------------------
    // Protocol state
    // ------------------------------------------------------------------
    state_t           state_reg;
    logic [CNT_W-1:0] count_reg;
    logic [WIDTH-2:0] rx_shift_reg;   // first WIDTH-1 bits of the current word
    logic [WIDTH-1:0] tx_shift_reg;
    logic [WIDTH-1:0] hold_reg;
    logic             hold_full_reg;
    logic [WIDTH-1:0] rx_word_reg;
    logic             rx_ready_reg;
    logic             underrun_reg;
    logic             frame_err_reg;
    logic             miso_reg;
    logic             miso_oe_reg;
    // Next shift edge must load a new word (a word has just completed).
    logic             word_start_reg;
    // CPHA=1 only: next shift edge drives the MSB already loaded at frame start.
    logic             drive_msb_reg;

    logic             cs_edge;
    logic             sample_edge;
    logic             shift_edge;
    logic             frame_start;
    logic             act_sample;
    logic             act_shift;
    logic             load_now;
    logic             tx_accept;
    logic [WIDTH-1:0] load_word;
    logic [WIDTH-1:0] rx_shift_next;

    assign cs_edge     = cs_rise | cs_fall;
    assign sample_edge = SAMPLE_ON_RISE ? sclk_rise : sclk_fall;
    assign shift_edge  = SAMPLE_ON_RISE ? sclk_fall : sclk_rise;

    // CS edges win over an SCLK edge seen in the same cycle.
    assign frame_start = (state_reg == ST_IDLE) & cs_fall;
    assign act_sample  = (state_reg == ST_ACTIVE) & ~cs_edge & sample_edge;
    assign act_shift   = (state_reg == ST_ACTIVE) & ~cs_edge & shift_edge;

    // A word is loaded at frame start and on the shift edge that follows a
    // completed word.
    assign load_now  = frame_start | (act_shift & word_start_reg);
    // Holding register only accepts when empty; a word accepted in the same
    // cycle as a load is not bypassed into the shift register.
    assign tx_accept = iTxValid & ~hold_full_reg;

    always_comb begin
        load_word     = hold_full_reg ? hold_reg : TX_FILL;
        rx_shift_next = {rx_shift_reg, mosi_s};
    end

    always_ff @(posedge sysclk or negedge nReset) begin
        if (!nReset) begin
            state_reg      <= ST_IDLE;
            count_reg      <= '0;
            rx_shift_reg   <= '0;
            tx_shift_reg   <= '0;
            hold_reg       <= '0;
            hold_full_reg  <= 1'b0;
            rx_word_reg    <= '0;
            rx_ready_reg   <= 1'b0;
            underrun_reg   <= 1'b0;
            frame_err_reg  <= 1'b0;
            miso_reg       <= 1'b0;
            miso_oe_reg    <= 1'b0;
            word_start_reg <= 1'b0;
            drive_msb_reg  <= 1'b0;
        end else begin
            rx_ready_reg  <= 1'b0;
            underrun_reg  <= 1'b0;
            frame_err_reg <= 1'b0;

            // Holding register: a load empties it, an accept fills it. Both
            // in the same cycle leave it full with the newly accepted word.
            if (tx_accept) begin
                hold_reg <= iTx;
            end
            if (load_now) begin
                hold_full_reg <= tx_accept;
                tx_shift_reg  <= load_word;
                underrun_reg  <= ~hold_full_reg;
            end else if (tx_accept) begin
                hold_full_reg <= 1'b1;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state_reg      <= ST_ACTIVE;
                        count_reg      <= '0;
                        miso_oe_reg    <= 1'b1;
                        word_start_reg <= 1'b0;
                        drive_msb_reg  <= SHIFT_FIRST;
                        // CPHA=0 presents the MSB before the first SCLK edge;
                        // CPHA=1 waits for the first shift edge.
                        if (!SHIFT_FIRST) begin
                            miso_reg <= load_word[WIDTH-1];
                        end
                    end
                end

                ST_ACTIVE: begin
                    if (cs_rise) begin
                        // Partial RX word and the word in the TX shift
                        // register are dropped; the holding register stays.
                        state_reg      <= ST_IDLE;
                        miso_reg       <= 1'b0;
                        miso_oe_reg    <= 1'b0;
                        count_reg      <= '0;
                        word_start_reg <= 1'b0;
                        drive_msb_reg  <= 1'b0;
                        if (count_reg != '0) begin
                            frame_err_reg <= 1'b1;
                        end
                    end else if (act_sample) begin
                        rx_shift_reg <= rx_shift_next[WIDTH-2:0];
                        if (count_reg == LAST_BIT) begin
                            rx_word_reg    <= rx_shift_next;
                            rx_ready_reg   <= 1'b1;
                            count_reg      <= '0;
                            word_start_reg <= 1'b1;
                        end else begin
                            count_reg <= count_reg + CNT_W'(1);
                        end
                    end else if (act_shift) begin
                        if (drive_msb_reg) begin
                            miso_reg      <= tx_shift_reg[WIDTH-1];
                            drive_msb_reg <= 1'b0;
                        end else if (word_start_reg) begin
                            // tx_shift_reg is loaded by the load_now path above.
                            miso_reg       <= load_word[WIDTH-1];
                            word_start_reg <= 1'b0;
                        end else begin
                            miso_reg     <= tx_shift_reg[WIDTH-2];
                            tx_shift_reg <= {tx_shift_reg[WIDTH-2:0], 1'b0};
                        end
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign oRx         = rx_word_reg;
    assign oRxReady    = rx_ready_reg;
    assign oTxReady    = ~hold_full_reg;
    assign oTxUnderrun = underrun_reg;
    assign oFrameErr   = frame_err_reg;
    assign oSPIMISO    = miso_reg;
    assign oSPIMisoOe  = miso_oe_reg;

`ifdef SPI_SLAVE_PROBE_EN
    logic underrun_sticky_reg;
    logic frame_err_sticky_reg;

    always_ff @(posedge sysclk or negedge nReset) begin
        if (!nReset) begin
            underrun_sticky_reg  <= 1'b0;
            frame_err_sticky_reg <= 1'b0;
        end else begin
            if (underrun_reg) begin
                underrun_sticky_reg <= 1'b1;
            end
            if (frame_err_reg) begin
                frame_err_sticky_reg <= 1'b1;
            end
        end
    end

    assign probe = {(state_reg == ST_ACTIVE), hold_full_reg, underrun_sticky_reg,
                    frame_err_sticky_reg, 4'b0000, 8'(count_reg)};
`endif

endmodule

// File: tb/tb_spi_slave_sync.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_sync
//
// Directed bench for spi_slave_sync. Four instances cover the four SPI modes
// (index = CPOL*2 + CPHA); most scenarios run on the mode 0 instance. A small
// bit-banged master drives the pins; a negedge monitor counts output pulses
// and logs every received word.
// -----------------------------------------------------------------------------
module tb_spi_slave_sync;

    localparam int         PH       = 8;       // sysclk cycles per SCLK phase
    localparam int         CS_SETUP = 10;      // CS fall to first SCLK edge
    localparam logic [7:0] FILL     = 8'h96;

    logic       sysclk = 1'b0;
    logic       nReset = 1'b0;
    logic [7:0] rx        [4];
    logic       rx_ready  [4];
    logic [7:0] tx_data   [4];
    logic       tx_valid  [4];
    logic       tx_ready  [4];
    logic       underrun  [4];
    logic       frame_err [4];
    logic       sclk      [4];
    logic       mosi      [4];
    logic       cs        [4];
    logic       miso      [4];
    logic       miso_oe   [4];
`ifdef SPI_SLAVE_PROBE_EN
    logic [15:0] probe    [4];
`endif

    int n_checks = 0;
    int n_fails  = 0;

    int         rx_cnt [4] = '{default: 0};
    int         ur_cnt [4] = '{default: 0};
    int         fe_cnt [4] = '{default: 0};
    logic [7:0] rx_log [4][64];
    logic       rdy_log [4][64];   // oTxReady seen alongside each oRxReady

    logic [7:0] mosi_q   [3];
    logic [7:0] miso_cap [3];

    always #5 sysclk = ~sysclk;

    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        spi_slave_sync #(
            .WIDTH      (8),
            .CPOL       (gi / 2),
            .CPHA       (gi % 2),
            .SYNC_STAGES(2),
            .TX_FILL    (FILL)
        ) u_dut (
            .sysclk     (sysclk),
            .nReset     (nReset),
            .oRx        (rx[gi]),
            .oRxReady   (rx_ready[gi]),
            .iTx        (tx_data[gi]),
            .iTxValid   (tx_valid[gi]),
            .oTxReady   (tx_ready[gi]),
            .oTxUnderrun(underrun[gi]),
            .oFrameErr  (frame_err[gi]),
            .iSPIClk    (sclk[gi]),
            .iSPIMOSI   (mosi[gi]),
            .iSPICS     (cs[gi]),
            .oSPIMISO   (miso[gi]),
            .oSPIMisoOe (miso_oe[gi])
`ifdef SPI_SLAVE_PROBE_EN
            ,
            .probe      (probe[gi])
`endif
        );
    end

    // Pulse monitor, sampled on the inactive clock edge.
    always @(negedge sysclk) begin
        for (int k = 0; k < 4; k++) begin
            if (rx_ready[k] === 1'b1) begin
                rx_log[k][rx_cnt[k] % 64]  = rx[k];
                rdy_log[k][rx_cnt[k] % 64] = tx_ready[k];
                rx_cnt[k]++;
            end
            if (underrun[k] === 1'b1) ur_cnt[k]++;
            if (frame_err[k] === 1'b1) fe_cnt[k]++;
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic push_tx(input int m, input logic [7:0] w);
        int n;
        n = 0;
        while (tx_ready[m] !== 1'b1 && n < 200) begin
            wait_clks(1);
            n++;
        end
        if (n >= 200) begin
            n_checks++;
            n_fails++;
            $display("FAIL push_tx_timeout: mode%0d oTxReady=%b required 1", m, tx_ready[m]);
        end
        tx_data[m]  = w;
        tx_valid[m] = 1'b1;
        wait_clks(1);
        tx_valid[m] = 1'b0;
    endtask

    // One bit as the master sees it; mi is MISO captured at the sample edge.
    task automatic spi_bit(input int m, input logic b, input bit last, output logic mi);
        logic pol;
        pol = (m >= 2);
        if (m % 2 == 0) begin
            mosi[m] = b;
            wait_clks(PH);
            sclk[m] = ~pol;            // leading edge = sample
            mi = miso[m];
            wait_clks(PH);
            if (last) begin
                cs[m] = 1'b1;          // release CS before returning SCLK idle
                wait_clks(PH);
            end
            sclk[m] = pol;
        end else begin
            sclk[m] = ~pol;            // leading edge = shift
            mosi[m] = b;
            wait_clks(PH);
            sclk[m] = pol;             // trailing edge = sample
            mi = miso[m];
            wait_clks(PH);
            if (last) cs[m] = 1'b1;
        end
    endtask

    task automatic spi_frame(input int m, input int nbits);
        logic mi;
        int   w;
        int   i;
        cs[m] = 1'b0;
        wait_clks(CS_SETUP);
        for (int b = 0; b < nbits; b++) begin
            w = b / 8;
            i = 7 - (b % 8);
            spi_bit(m, mosi_q[w][i], (b == nbits - 1), mi);
            miso_cap[w][i] = mi;
        end
        wait_clks(PH * 2);
        $display("frame mode%0d bits=%0d mosi0=%h miso0=%h oRx=%h", m, nbits, mosi_q[0], miso_cap[0], rx[m]);
    endtask

    task automatic test_reset();
        nReset = 1'b0;
        wait_clks(4);
        nReset = 1'b1;
        wait_clks(6);
        n_checks++; if (rx[0] !== 8'h00) begin n_fails++; $display("FAIL reset_rx: got %h need 00", rx[0]); end
        n_checks++; if (rx_ready[0] !== 1'b0) begin n_fails++; $display("FAIL reset_rxready: got %b need 0", rx_ready[0]); end
        n_checks++; if (tx_ready[0] !== 1'b1) begin n_fails++; $display("FAIL reset_txready: got %b need 1", tx_ready[0]); end
        n_checks++; if (underrun[0] !== 1'b0 || frame_err[0] !== 1'b0) begin n_fails++; $display("FAIL reset_pulses: ur=%b fe=%b need 0 0", underrun[0], frame_err[0]); end
        n_checks++; if (miso[0] !== 1'b0 || miso_oe[0] !== 1'b0) begin n_fails++; $display("FAIL reset_miso: miso=%b oe=%b need 0 0", miso[0], miso_oe[0]); end
    endtask

    // Single word in each mode: hold A5, receive 3C.
    task automatic test_modes(input int m_first, input int m_last);
        int rx0;
        int ur0;
        for (int m = m_first; m <= m_last; m++) begin
            push_tx(m, 8'hA5);
            n_checks++; if (tx_ready[m] !== 1'b0) begin n_fails++; $display("FAIL m%0d_hold_full: oTxReady=%b need 0", m, tx_ready[m]); end
            rx0 = rx_cnt[m];
            ur0 = ur_cnt[m];
            mosi_q[0] = 8'h3C;
            spi_frame(m, 8);
            n_checks++; if (rx[m] !== 8'h3C) begin n_fails++; $display("FAIL m%0d_rx: got %h need 3c", m, rx[m]); end
            n_checks++; if (rx_cnt[m] - rx0 != 1) begin n_fails++; $display("FAIL m%0d_rxready_count: got %0d need 1", m, rx_cnt[m] - rx0); end
            n_checks++; if (miso_cap[0] !== 8'hA5) begin n_fails++; $display("FAIL m%0d_miso: got %h need a5", m, miso_cap[0]); end
            n_checks++; if (ur_cnt[m] - ur0 != 0) begin n_fails++; $display("FAIL m%0d_underrun: got %0d need 0", m, ur_cnt[m] - ur0); end
            n_checks++; if (tx_ready[m] !== 1'b1 || miso_oe[m] !== 1'b0) begin n_fails++; $display("FAIL m%0d_after: txready=%b oe=%b need 1 0", m, tx_ready[m], miso_oe[m]); end
        end
    endtask

    task automatic test_back_to_back();
        int rx0;
        int ur0;
        push_tx(0, 8'hA5);
        rx0 = rx_cnt[0];
        ur0 = ur_cnt[0];
        mosi_q[0] = 8'h12;
        mosi_q[1] = 8'hB4;
        mosi_q[2] = 8'h6D;
        spi_frame(0, 24);
        n_checks++; if (rx_cnt[0] - rx0 != 3) begin n_fails++; $display("FAIL b2b_rx_count: got %0d need 3", rx_cnt[0] - rx0); end
        n_checks++; if (rx_log[0][(rx0 + 0) % 64] !== 8'h12 || rx_log[0][(rx0 + 1) % 64] !== 8'hB4 || rx_log[0][(rx0 + 2) % 64] !== 8'h6D) begin
            n_fails++; $display("FAIL b2b_rx_words: got %h %h %h need 12 b4 6d", rx_log[0][(rx0 + 0) % 64], rx_log[0][(rx0 + 1) % 64], rx_log[0][(rx0 + 2) % 64]);
        end
        n_checks++; if (miso_cap[0] !== 8'hA5 || miso_cap[1] !== FILL || miso_cap[2] !== FILL) begin
            n_fails++; $display("FAIL b2b_miso: got %h %h %h need a5 96 96", miso_cap[0], miso_cap[1], miso_cap[2]);
        end
        n_checks++; if (ur_cnt[0] - ur0 != 2) begin n_fails++; $display("FAIL b2b_underrun: got %0d need 2", ur_cnt[0] - ur0); end
    endtask

    task automatic test_frame_err();
        int rx0;
        int fe0;
        rx0 = rx_cnt[0];
        fe0 = fe_cnt[0];
        mosi_q[0] = 8'h5A;
        spi_frame(0, 5);
        n_checks++; if (fe_cnt[0] - fe0 != 1) begin n_fails++; $display("FAIL ferr_pulse: got %0d need 1", fe_cnt[0] - fe0); end
        n_checks++; if (rx_cnt[0] - rx0 != 0) begin n_fails++; $display("FAIL ferr_no_rxready: got %0d need 0", rx_cnt[0] - rx0); end
        n_checks++; if (rx[0] !== 8'h6D) begin n_fails++; $display("FAIL ferr_rx_kept: got %h need 6d", rx[0]); end
        mosi_q[0] = 8'hFF;
        spi_frame(0, 8);
        n_checks++; if (rx[0] !== 8'hFF || rx_cnt[0] - rx0 != 1) begin n_fails++; $display("FAIL ferr_next_frame: rx=%h cnt=%0d need ff 1", rx[0], rx_cnt[0] - rx0); end
        n_checks++; if (fe_cnt[0] - fe0 != 1) begin n_fails++; $display("FAIL ferr_clean_frame: got %0d need 1", fe_cnt[0] - fe0); end
    endtask

    // iTxValid asserted exactly in the frame-start load cycle.
    task automatic test_tx_in_load_cycle();
        int ur0;
        int rx0;
        n_checks++; if (tx_ready[0] !== 1'b1) begin n_fails++; $display("FAIL t5_start_empty: oTxReady=%b need 1", tx_ready[0]); end
        ur0 = ur_cnt[0];
        rx0 = rx_cnt[0];
        cs[0] = 1'b0;                 // pin registered at the next edge
        wait_clks(2);                 // fall is visible to the FSM this cycle
        tx_data[0]  = 8'h5C;
        tx_valid[0] = 1'b1;
        wait_clks(1);
        tx_valid[0] = 1'b0;
        n_checks++; if (underrun[0] !== 1'b1) begin n_fails++; $display("FAIL t5_underrun_now: got %b need 1", underrun[0]); end
        n_checks++; if (tx_ready[0] !== 1'b0) begin n_fails++; $display("FAIL t5_captured: oTxReady=%b need 0", tx_ready[0]); end
        mosi_q[0] = 8'hE7;
        mosi_q[1] = 8'h18;
        spi_frame(0, 16);
        n_checks++; if (miso_cap[0] !== FILL || miso_cap[1] !== 8'h5C) begin n_fails++; $display("FAIL t5_miso: got %h %h need 96 5c", miso_cap[0], miso_cap[1]); end
        n_checks++; if (ur_cnt[0] - ur0 != 1) begin n_fails++; $display("FAIL t5_underrun_count: got %0d need 1", ur_cnt[0] - ur0); end
        n_checks++; if (rdy_log[0][rx0 % 64] !== 1'b0) begin n_fails++; $display("FAIL t5_ready_low_word1: oTxReady=%b need 0", rdy_log[0][rx0 % 64]); end
        n_checks++; if (tx_ready[0] !== 1'b1 || rx[0] !== 8'h18) begin n_fails++; $display("FAIL t5_end: txready=%b rx=%h need 1 18", tx_ready[0], rx[0]); end
    endtask

    task automatic test_reset_mid_frame();
        logic mi;
        int   rx0;
        int   fe0;
        push_tx(0, 8'hA5);
        cs[0] = 1'b0;
        wait_clks(CS_SETUP);
        for (int b = 0; b < 4; b++) spi_bit(0, 1'b1, 1'b0, mi);
        nReset = 1'b0;
        wait_clks(2);
        n_checks++; if (rx[0] !== 8'h00 || rx_ready[0] !== 1'b0) begin n_fails++; $display("FAIL t6_rx: rx=%h rdy=%b need 00 0", rx[0], rx_ready[0]); end
        n_checks++; if (tx_ready[0] !== 1'b1) begin n_fails++; $display("FAIL t6_txready: got %b need 1", tx_ready[0]); end
        n_checks++; if (miso[0] !== 1'b0 || miso_oe[0] !== 1'b0 || underrun[0] !== 1'b0 || frame_err[0] !== 1'b0) begin
            n_fails++; $display("FAIL t6_outputs: miso=%b oe=%b ur=%b fe=%b need 0 0 0 0", miso[0], miso_oe[0], underrun[0], frame_err[0]);
        end
        nReset = 1'b1;
        rx0 = rx_cnt[0];
        fe0 = fe_cnt[0];
        wait_clks(4);
        for (int b = 0; b < 8; b++) spi_bit(0, 1'b1, 1'b0, mi);
        wait_clks(PH);
        n_checks++; if (rx_cnt[0] - rx0 != 0 || miso_oe[0] !== 1'b0) begin n_fails++; $display("FAIL t6_ignored: rxcnt=%0d oe=%b need 0 0", rx_cnt[0] - rx0, miso_oe[0]); end
        cs[0] = 1'b1;
        wait_clks(CS_SETUP);
        n_checks++; if (fe_cnt[0] - fe0 != 0) begin n_fails++; $display("FAIL t6_no_ferr: got %0d need 0", fe_cnt[0] - fe0); end
        mosi_q[0] = 8'h3C;
        spi_frame(0, 8);
        n_checks++; if (rx[0] !== 8'h3C || rx_cnt[0] - rx0 != 1) begin n_fails++; $display("FAIL t6_new_frame: rx=%h cnt=%0d need 3c 1", rx[0], rx_cnt[0] - rx0); end
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            tx_data[k]  = 8'h00;
            tx_valid[k] = 1'b0;
            sclk[k]     = (k >= 2);
            mosi[k]     = 1'b0;
            cs[k]       = 1'b1;
        end
        test_reset();
        test_modes(0, 0);
        test_modes(1, 3);
        test_back_to_back();
        test_frame_err();
        test_tx_in_load_cycle();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog expired");
    end

endmodule
